// File: rtl/venom_shot_ctrl.sv
// venom_shot_ctrl
//   Fire-key edge detector, single projectile mover and magazine reload timer.
//   A fresh press of the fire key launches a shot from the snake head in the
//   snake's current direction; the shot moves SPEED pixels per frame tick until
//   it leaves the playfield. When the magazine is empty (venomCount == 3) a
//   frame-tick timer runs and then requests a reload until the counter refills.
//
//   Build option: define VENOM_WRAP_EN to make shots wrap around the playfield
//   edges and despawn after LIFETIME_FRAMES frame ticks instead.
//
// Ports
//   Clk          in   1   clock
//   Reset        in   1   asynchronous, active-high
//   frame_tick   in   1   one-Clk pulse per video frame
//   keycode      in  16   two concurrent key bytes
//   fireKeycode  in   8   fire key; 0x00 disables firing
//   venomCount   in   2   shots used (3 = empty)
//   snakeX/Y     in  10   snake head position
//   snakeDir     in   2   00 up, 01 down, 10 left, 11 right
//   venomActive  out  1   projectile on screen
//   venomX/Y     out 10   projectile position
//   reload       out  1   reload request to the venom counter
//   reloadBusy   out  1   reload timer running
module venom_shot_ctrl #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SPEED           = 4,
  parameter int RELOAD_FRAMES   = 120,
  parameter int LIFETIME_FRAMES = 200
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  input  logic [7:0]  fireKeycode,
  input  logic [1:0]  venomCount,
  input  logic [9:0]  snakeX,
  input  logic [9:0]  snakeY,
  input  logic [1:0]  snakeDir,
  output logic        venomActive,
  output logic [9:0]  venomX,
  output logic [9:0]  venomY,
  output logic        reload,
  output logic        reloadBusy
);

  localparam int RW = $clog2(RELOAD_FRAMES + 1);
  localparam logic signed [10:0] SPD  = 11'(SPEED);
  localparam logic signed [10:0] XLIM = 11'(SCREEN_W);
  localparam logic signed [10:0] YLIM = 11'(SCREEN_H);

  typedef enum logic {P_IDLE, P_FLY} p_state_t;
  typedef enum logic [1:0] {R_IDLE, R_COUNT, R_ACK} r_state_t;

  // True when a candidate coordinate lies inside [0, lim-1].
  function automatic logic f_in_range(input logic signed [10:0] v,
                                      input logic signed [10:0] lim);
    return (v >= 11'sd0) && (v < lim);
  endfunction

`ifdef VENOM_WRAP_EN
  // A single SPEED step can overshoot by less than one screen, so one
  // correction brings the coordinate back into [0, lim-1].
  function automatic logic [9:0] f_wrap(input logic signed [10:0] v,
                                        input logic signed [10:0] lim);
    logic signed [10:0] t;
    t = v;
    if (v < 11'sd0)
      t = v + lim;
    else if (v >= lim)
      t = v - lim;
    return t[9:0];
  endfunction
`endif

  p_state_t r_pstate, w_pstate_nxt;
  r_state_t r_rstate, w_rstate_nxt;

  logic          r_fire_prev;
  logic [9:0]    r_x, r_y;
  logic [1:0]    r_dir;
  logic [RW-1:0] r_rcnt;

  logic w_fire_hit, w_press, w_launch, w_empty, w_move;
  logic signed [10:0] w_nx, w_ny;

  // Fire detection: a zero fire key must never match an idle keycode byte.
  assign w_fire_hit = (fireKeycode != 8'h00) &&
                      ((keycode[15:8] == fireKeycode) || (keycode[7:0] == fireKeycode));
  assign w_press    = w_fire_hit & ~r_fire_prev;
  assign w_empty    = (venomCount == 2'd3);
  assign w_launch   = w_press & ~w_empty;
  // Launch has priority over movement in the same cycle.
  assign w_move     = (r_pstate == P_FLY) & frame_tick & ~w_launch;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_fire_prev <= 1'b0;
    else       r_fire_prev <= w_fire_hit;
  end

  // Candidate next position, signed 11 bits so underflow is visible.
  always_comb begin
    w_nx = signed'({1'b0, r_x});
    w_ny = signed'({1'b0, r_y});
    case (r_dir)
      2'b00:   w_ny = signed'({1'b0, r_y}) - SPD;
      2'b01:   w_ny = signed'({1'b0, r_y}) + SPD;
      2'b10:   w_nx = signed'({1'b0, r_x}) - SPD;
      default: w_nx = signed'({1'b0, r_x}) + SPD;
    endcase
  end

`ifdef VENOM_WRAP_EN
  localparam int LW = $clog2(LIFETIME_FRAMES + 1);
  logic [LW-1:0] r_life;
  logic          w_despawn;

  assign w_despawn = w_move & (r_life == LW'(LIFETIME_FRAMES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         r_life <= '0;
    else if (w_launch) r_life <= '0;
    else if (w_move)   r_life <= r_life + LW'(1);
  end
`else
  logic w_despawn;
  assign w_despawn = w_move & ~(f_in_range(w_nx, XLIM) & f_in_range(w_ny, YLIM));
`endif

  // Projectile position and latched direction.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_dir <= 2'b00;
    end else if (w_launch) begin
      r_x   <= snakeX;
      r_y   <= snakeY;
      r_dir <= snakeDir;
    end else if (w_move && !w_despawn) begin
`ifdef VENOM_WRAP_EN
      r_x <= f_wrap(w_nx, XLIM);
      r_y <= f_wrap(w_ny, YLIM);
`else
      r_x <= w_nx[9:0];
      r_y <= w_ny[9:0];
`endif
    end
  end

  // Projectile FSM: state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_pstate <= P_IDLE;
    else       r_pstate <= w_pstate_nxt;
  end

  // Projectile FSM: next state
  always_comb begin
    w_pstate_nxt = r_pstate;
    case (r_pstate)
      P_IDLE:  if (w_launch) w_pstate_nxt = P_FLY;
      default: begin
        if (w_launch)       w_pstate_nxt = P_FLY;
        else if (w_despawn) w_pstate_nxt = P_IDLE;
      end
    endcase
  end

  // Projectile FSM: outputs
  always_comb begin
    venomActive = (r_pstate == P_FLY);
    venomX      = r_x;
    venomY      = r_y;
  end

  // Reload frame counter; cleared whenever the timer is not running.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                r_rcnt <= '0;
    else if (r_rstate != R_COUNT)             r_rcnt <= '0;
    else if (frame_tick)                      r_rcnt <= r_rcnt + RW'(1);
  end

  // Reload FSM: state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  // Reload FSM: next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_empty) w_rstate_nxt = R_COUNT;
      R_COUNT: begin
        // Magazine refilled by other means: abort without a request.
        if (!w_empty)
          w_rstate_nxt = R_IDLE;
        else if (frame_tick && r_rcnt == RW'(RELOAD_FRAMES - 1))
          w_rstate_nxt = R_ACK;
      end
      R_ACK:   if (!w_empty) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Reload FSM: outputs
  always_comb begin
    reload     = (r_rstate == R_ACK);
    reloadBusy = (r_rstate == R_COUNT);
  end

endmodule

// File: tb/tb_venom_shot_ctrl.sv
module tb_venom_shot_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [15:0] keycode = 16'h0000;
  logic [7:0]  fireKeycode = 8'h2C;
  logic [1:0]  venomCount = 2'd0;
  logic [9:0]  snakeX = 10'd0;
  logic [9:0]  snakeY = 10'd0;
  logic [1:0]  snakeDir = 2'b00;
  logic        venomActive;
  logic [9:0]  venomX;
  logic [9:0]  venomY;
  logic        reload;
  logic        reloadBusy;

  int total = 0;
  int bad   = 0;

  venom_shot_ctrl #(
    .SCREEN_W(640), .SCREEN_H(480), .SPEED(4),
    .RELOAD_FRAMES(4), .LIFETIME_FRAMES(200)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .fireKeycode(fireKeycode), .venomCount(venomCount),
    .snakeX(snakeX), .snakeY(snakeY), .snakeDir(snakeDir),
    .venomActive(venomActive), .venomX(venomX), .venomY(venomY),
    .reload(reload), .reloadBusy(reloadBusy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] key;
    logic [9:0]  sx, sy;
    logic [1:0]  sd;
    logic        tick;
    logic        e_act;
    logic [9:0]  e_x, e_y;
  } vec_t;

  typedef struct {
    logic [9:0] sx, sy;
    logic [1:0] sd;
    logic       e_act;
    logic [9:0] e_x, e_y;
  } bnd_t;

  vec_t tbl[$];
  bnd_t bnd[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [15:0] key, input int sx, input int sy,
                              input logic [1:0] sd, input logic tick,
                              input logic e_act, input int e_x, input int e_y);
    vec_t v;
    v.key = key; v.sx = 10'(sx); v.sy = 10'(sy); v.sd = sd; v.tick = tick;
    v.e_act = e_act; v.e_x = 10'(e_x); v.e_y = 10'(e_y);
    return v;
  endfunction

  function automatic bnd_t mkb(input int sx, input int sy, input logic [1:0] sd,
                               input logic e_act, input int e_x, input int e_y);
    bnd_t b;
    b.sx = 10'(sx); b.sy = 10'(sy); b.sd = sd;
    b.e_act = e_act; b.e_x = 10'(e_x); b.e_y = 10'(e_y);
    return b;
  endfunction

  initial begin
    // Held key, three ticks, relaunch on new edge with simultaneous tick.
    tbl.push_back(mk(16'h0000, 100, 200, 2'b11, 1'b0, 1'b0,   0,   0));
    tbl.push_back(mk(16'h002C, 100, 200, 2'b11, 1'b0, 1'b1, 100, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b0, 1'b1, 100, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b1, 1'b1, 104, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b0, 1'b1, 104, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b1, 1'b1, 108, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b0, 1'b1, 108, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b1, 1'b1, 112, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b0, 1'b1, 112, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b0, 1'b1, 112, 200));
    tbl.push_back(mk(16'h002C, 300, 220, 2'b11, 1'b0, 1'b1, 112, 200));
    tbl.push_back(mk(16'h0000, 300, 220, 2'b11, 1'b0, 1'b1, 112, 200));
    tbl.push_back(mk(16'h2C00,  50,  60, 2'b00, 1'b1, 1'b1,  50,  60));
    tbl.push_back(mk(16'h2C00,  50,  60, 2'b00, 1'b1, 1'b1,  50,  56));
    tbl.push_back(mk(16'h0000,  50,  60, 2'b01, 1'b1, 1'b1,  50,  52));
    tbl.push_back(mk(16'h1234,  70,  80, 2'b10, 1'b0, 1'b1,  50,  52));

`ifdef VENOM_WRAP_EN
    bnd.push_back(mkb(638, 100, 2'b11, 1'b1,   2, 100));
    bnd.push_back(mkb( 10,   2, 2'b00, 1'b1,  10, 478));
    bnd.push_back(mkb(  3, 100, 2'b10, 1'b1, 639, 100));
    bnd.push_back(mkb( 20, 478, 2'b01, 1'b1,  20,   2));
`else
    bnd.push_back(mkb(638, 100, 2'b11, 1'b0, 638, 100));
    bnd.push_back(mkb( 10,   2, 2'b00, 1'b0,  10,   2));
    bnd.push_back(mkb(  3, 100, 2'b10, 1'b0,   3, 100));
    bnd.push_back(mkb( 20, 478, 2'b01, 1'b0,  20, 478));
`endif
    bnd.push_back(mkb(635, 100, 2'b11, 1'b1, 639, 100));
    bnd.push_back(mkb(  4, 100, 2'b10, 1'b1,   0, 100));

    // Reset state
    step();
    chk("rst_active", venomActive, 0);
    chk("rst_x", venomX, 0);
    chk("rst_y", venomY, 0);
    chk("rst_reload", reload, 0);
    chk("rst_busy", reloadBusy, 0);
    Reset = 1'b0;

    // Table-driven vectors
    foreach (tbl[i]) begin
      keycode = tbl[i].key; snakeX = tbl[i].sx; snakeY = tbl[i].sy;
      snakeDir = tbl[i].sd; frame_tick = tbl[i].tick;
      step();
      chk($sformatf("tbl%0d_active", i), venomActive, tbl[i].e_act);
      chk($sformatf("tbl%0d_x", i), venomX, tbl[i].e_x);
      chk($sformatf("tbl%0d_y", i), venomY, tbl[i].e_y);
      chk($sformatf("tbl%0d_busy", i), reloadBusy, 0);
    end
    frame_tick = 1'b0;

    // Playfield edges
    foreach (bnd[i]) begin
      do_reset();
      keycode = 16'h0000; step();
      keycode = 16'h002C; snakeX = bnd[i].sx; snakeY = bnd[i].sy; snakeDir = bnd[i].sd;
      step();
      chk($sformatf("bnd%0d_launch", i), venomActive, 1);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      chk($sformatf("bnd%0d_active", i), venomActive, bnd[i].e_act);
      chk($sformatf("bnd%0d_x", i), venomX, bnd[i].e_x);
      chk($sformatf("bnd%0d_y", i), venomY, bnd[i].e_y);
    end

    // Zero fire key never fires, even on an all-zero keycode
    do_reset();
    fireKeycode = 8'h00; keycode = 16'h0000;
    step(); step();
    chk("fk0_active", venomActive, 0);
    fireKeycode = 8'h2C;

    // Empty magazine: press ignored, reload timer, request, release
    do_reset();
    venomCount = 2'd3; keycode = 16'h0000;
    step();
    chk("empty_busy", reloadBusy, 1);
    keycode = 16'h002C; snakeX = 100; snakeY = 100; snakeDir = 2'b11;
    step();
    chk("empty_nolaunch", venomActive, 0);
    frame_tick = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      step();
      chk($sformatf("rl_tick%0d_reload", t), reload, (t == 4) ? 1 : 0);
      chk($sformatf("rl_tick%0d_busy", t), reloadBusy, (t == 4) ? 0 : 1);
    end
    frame_tick = 1'b0;
    step();
    chk("rl_hold", reload, 1);
    chk("rl_hold_active", venomActive, 0);
    venomCount = 2'd0;
    step();
    chk("rl_drop", reload, 0);
    chk("rl_drop_busy", reloadBusy, 0);

    // Reset during reload count
    do_reset();
    keycode = 16'h0000; venomCount = 2'd3;
    step();
    frame_tick = 1'b1; step(); step(); frame_tick = 1'b0;
    chk("rc_busy_pre", reloadBusy, 1);
    Reset = 1'b1;
    #2;
    chk("rc_reload_async", reload, 0);
    chk("rc_busy_async", reloadBusy, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    frame_tick = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      step();
      chk($sformatf("rc_after%0d_reload", t), reload, 0);
    end
    frame_tick = 1'b0;
    venomCount = 2'd0;
    step();

    // Held key through reset relaunches; shot keeps flying during reload
    do_reset();
    keycode = 16'h002C; snakeX = 100; snakeY = 200; snakeDir = 2'b11;
    step();
    chk("hr_launch", venomActive, 1);
    Reset = 1'b1;
    #2;
    chk("hr_active_async", venomActive, 0);
    chk("hr_x_async", venomX, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    snakeX = 150;
    step();
    chk("hr_relaunch", venomActive, 1);
    chk("hr_relaunch_x", venomX, 150);
    venomCount = 2'd3; frame_tick = 1'b1;
    step();
    chk("fly_rl_x1", venomX, 154);
    chk("fly_rl_busy1", reloadBusy, 1);
    step();
    chk("fly_rl_x2", venomX, 158);
    chk("fly_rl_active", venomActive, 1);
    frame_tick = 1'b0; venomCount = 2'd0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
